bomb_controller: RTL and testbench

Two-channel bomb timer and blast resolver that produces the `p1die` / `p2die` inputs consumed by the game-state controller. Each player owns one bomb slot. The slot is armed by a keypress, placed at the player's current tile, and runs a frame-counted fuse followed by a three-phase explosion. A player whose tile lies inside any active blast is flagged dead. The block sits between the keyboard/player-position logic and the game-state controller, and it also feeds bomb position and phase to the sprite renderer.

---
 rtl/bomb_controller.sv | 210 +++++++++++++++++++++
 tb/tb_bomb_controller.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bomb_controller.sv
// bomb_controller: two independent bomb slots (one per player), each running a
// frame-counted fuse and a three-phase plus-shaped explosion, plus sticky
// per-player death flags derived from the active blasts.
module bomb_controller #(
    parameter int FUSE_FRAMES  = 120,
    parameter int PHASE_FRAMES = 20,
    parameter int RADIUS       = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [4:0] game_state,
    input  logic [7:0] keycode,
    input  logic [3:0] p1_tx,
    input  logic [3:0] p1_ty,
    input  logic [3:0] p2_tx,
    input  logic [3:0] p2_ty,
    output logic       p1die,
    output logic       p2die,
    output logic [3:0] b1_tx,
    output logic [3:0] b1_ty,
    output logic [3:0] b2_tx,
    output logic [3:0] b2_ty,
    output logic [2:0] b1_phase,
    output logic [2:0] b2_phase
);

    // Slot states double as the phase code seen by the renderer.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FUSE = 3'd1,
        S_EX1  = 3'd2,
        S_EX2  = 3'd3,
        S_EX3  = 3'd4
    } slot_state_t;

    typedef struct packed {
        slot_state_t st;
        logic [7:0]  cnt;
        logic [3:0]  bx;
        logic [3:0]  by;
    } slot_t;

    localparam logic [4:0] GS_PLAY    = 5'b11000;
    localparam logic [4:0] GS_PAUSE   = 5'b11111;
    localparam logic [7:0] KEY_P1     = 8'h19;
    localparam logic [7:0] KEY_P2     = 8'h13;
    localparam logic [7:0] FUSE_LAST  = 8'(FUSE_FRAMES - 1);
    localparam logic [7:0] PHASE_LAST = 8'(PHASE_FRAMES - 1);
    localparam logic [4:0] R_SMALL    = 5'd1;
    localparam logic [4:0] R_BIG      = 5'(RADIUS);

    slot_t      slot_q [2];
    slot_t      slot_d [2];
    logic [7:0] prev_key;
    logic       in_play;
    logic       in_pause;
    logic [1:0] place;
    logic [1:0] hit;
    logic       p1die_d;
    logic       p2die_d;

    function automatic logic [7:0] place_key(input int idx);
        return (idx == 0) ? KEY_P1 : KEY_P2;
    endfunction

    // Distance between two tiles along one axis, widened so max-min never wraps.
    function automatic logic [4:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
        if (a > b)
            return {1'b0, a} - {1'b0, b};
        else
            return {1'b0, b} - {1'b0, a};
    endfunction

    // True when tile (x,y) lies on the plus-shaped blast of slot s.
    function automatic logic in_blast(input slot_t s, input logic [3:0] x, input logic [3:0] y);
        logic [4:0] r;
        logic       active;
        r      = (s.st == S_EX2) ? R_BIG : R_SMALL;
        active = (s.st == S_EX1) || (s.st == S_EX2) || (s.st == S_EX3);
        return active && (((x == s.bx) && (abs_diff(y, s.by) <= r)) ||
                          ((y == s.by) && (abs_diff(x, s.bx) <= r)));
    endfunction

    assign in_play  = (game_state == GS_PLAY);
    assign in_pause = (game_state == GS_PAUSE);

    // Placement request: rising edge of the slot's key, idle slot, play state only.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            place[i] = in_play && (slot_q[i].st == S_IDLE) &&
                       (prev_key != place_key(i)) && (keycode == place_key(i));
        end
    end

    // Per-slot next state: fuse and explosion phases advanced by frame ticks.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            // NOTE: every combinational output gets its hold value first, so no path infers a latch.
            slot_d[i] = slot_q[i];
            if (!in_play && !in_pause) begin
                slot_d[i].st  = S_IDLE;
                slot_d[i].cnt = '0;
            end else if (in_play) begin
                case (slot_q[i].st)
                    S_IDLE: begin
                        if (place[i]) begin
                            slot_d[i].st  = S_FUSE;
                            slot_d[i].cnt = '0;
                            slot_d[i].bx  = (i == 0) ? p1_tx : p2_tx;
                            slot_d[i].by  = (i == 0) ? p1_ty : p2_ty;
                        end
                    end
                    S_FUSE: begin
                        if (frame_tick) begin
                            if (slot_q[i].cnt == FUSE_LAST) begin
                                slot_d[i].st  = S_EX1;
                                slot_d[i].cnt = '0;
                            end else begin
                                slot_d[i].cnt = slot_q[i].cnt + 8'd1;
                            end
                        end
                    end
                    S_EX1: begin
                        if (frame_tick) begin
                            if (slot_q[i].cnt == PHASE_LAST) begin
                                slot_d[i].st  = S_EX2;
                                slot_d[i].cnt = '0;
                            end else begin
                                slot_d[i].cnt = slot_q[i].cnt + 8'd1;
                            end
                        end
                    end
                    S_EX2: begin
                        if (frame_tick) begin
                            if (slot_q[i].cnt == PHASE_LAST) begin
                                slot_d[i].st  = S_EX3;
                                slot_d[i].cnt = '0;
                            end else begin
                                slot_d[i].cnt = slot_q[i].cnt + 8'd1;
                            end
                        end
                    end
                    S_EX3: begin
                        if (frame_tick) begin
                            if (slot_q[i].cnt == PHASE_LAST) begin
                                slot_d[i].st  = S_IDLE;
                                slot_d[i].cnt = '0;
                            end else begin
                                slot_d[i].cnt = slot_q[i].cnt + 8'd1;
                            end
                        end
                    end
                    default: begin
                        slot_d[i].st  = S_IDLE;
                        slot_d[i].cnt = '0;
                    end
                endcase
            end
        end
    end

    // Hit test of each player against both bombs, from the current registered phase.
    always_comb begin
        hit[0] = in_blast(slot_q[0], p1_tx, p1_ty) || in_blast(slot_q[1], p1_tx, p1_ty);
        hit[1] = in_blast(slot_q[0], p2_tx, p2_ty) || in_blast(slot_q[1], p2_tx, p2_ty);
    end

    // Sticky death flags: set by a hit in play, held in pause, cleared otherwise.
    always_comb begin
        p1die_d = 1'b0;
        p2die_d = 1'b0;
        if (in_play) begin
            p1die_d = p1die | hit[0];
            p2die_d = p2die | hit[1];
        end else if (in_pause) begin
            p1die_d = p1die;
            p2die_d = p2die;
        end
    end

    // State, previous keycode and death flag registers.
    always_ff @(posedge Clk) begin
        // NOTE: reset is synchronous and clears every register, so all outputs read 0 one edge after Reset.
        if (Reset) begin
            for (int i = 0; i < 2; i++) begin
                slot_q[i] <= '{st: S_IDLE, cnt: 8'd0, bx: 4'd0, by: 4'd0};
            end
            prev_key <= 8'h00;
            p1die    <= 1'b0;
            p2die    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            for (int i = 0; i < 2; i++) begin
                slot_q[i] <= slot_d[i];
            end
            prev_key <= keycode;
            p1die    <= p1die_d;
            p2die    <= p2die_d;
        end
    end

    assign b1_tx    = slot_q[0].bx;
    assign b1_ty    = slot_q[0].by;
    assign b2_tx    = slot_q[1].bx;
    assign b2_ty    = slot_q[1].by;
    assign b1_phase = slot_q[0].st;
    assign b2_phase = slot_q[1].st;

endmodule

// File: tb/tb_bomb_controller.sv
// Directed testbench for bomb_controller: placement, fuse/phase timing, blast
// radius, double kill, pause freeze, game exit and mid-explosion reset.
module tb_bomb_controller;

    localparam logic [4:0] GS_PLAY  = 5'b11000;
    localparam logic [4:0] GS_PAUSE = 5'b11111;
    localparam logic [4:0] GS_OTHER = 5'b10000;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_tick;
    logic [4:0] game_state;
    logic [7:0] keycode;
    logic [3:0] p1_tx, p1_ty, p2_tx, p2_ty;
    logic       p1die, p2die;
    logic [3:0] b1_tx, b1_ty, b2_tx, b2_ty;
    logic [2:0] b1_phase, b2_phase;

    int n_checks = 0;
    int n_errors = 0;

    bomb_controller #(
        .FUSE_FRAMES (120),
        .PHASE_FRAMES(20),
        .RADIUS      (2)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_tick(frame_tick),
        .game_state(game_state),
        .keycode   (keycode),
        .p1_tx     (p1_tx),
        .p1_ty     (p1_ty),
        .p2_tx     (p2_tx),
        .p2_ty     (p2_ty),
        .p1die     (p1die),
        .p2die     (p2die),
        .b1_tx     (b1_tx),
        .b1_ty     (b1_ty),
        .b2_tx     (b2_tx),
        .b2_ty     (b2_ty),
        .b1_phase  (b1_phase),
        .b2_phase  (b2_phase)
    );

    always #5 Clk = ~Clk;

    // One clock: inputs set before this call are captured; outputs sampled 1 after the edge.
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic run_ticks(input int n);
        frame_tick = 1'b1;
        repeat (n) cyc();
        frame_tick = 1'b0;
    endtask

    // Leave the game for one cycle to idle both slots, then re-enter play.
    task automatic clear_state();
        keycode    = 8'h00;
        frame_tick = 1'b0;
        game_state = GS_OTHER;
        cyc();
        game_state = GS_PLAY;
        cyc();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        frame_tick = 1'b0;
        game_state = GS_PLAY;
        keycode = 8'h00;
        p1_tx = 4'd0; p1_ty = 4'd0; p2_tx = 4'd0; p2_ty = 4'd0;
        cyc();
        cyc();
        Reset = 1'b0;
        n_checks++;
        if ({p1die, p2die, b1_tx, b1_ty, b2_tx, b2_ty} !== 18'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h, want 0", {p1die, p2die, b1_tx, b1_ty, b2_tx, b2_ty});
        end
        n_checks++;
        if ({b1_phase, b2_phase} !== 6'd0) begin
            n_errors++;
            $display("FAIL reset_phases: got %h, want 0", {b1_phase, b2_phase});
        end
    endtask

    task automatic test_placement();
        game_state = GS_PLAY;
        p1_tx = 4'd3; p1_ty = 4'd5;
        p2_tx = 4'd12; p2_ty = 4'd12;
        keycode = 8'h00;
        cyc();
        keycode = 8'h19;
        cyc();
        n_checks++;
        if (b1_phase !== 3'd1) begin
            n_errors++;
            $display("FAIL place_phase: got %0d, want 1", b1_phase);
        end
        n_checks++;
        if ({b1_tx, b1_ty} !== {4'd3, 4'd5}) begin
            n_errors++;
            $display("FAIL place_pos: got (%0d,%0d), want (3,5)", b1_tx, b1_ty);
        end
        n_checks++;
        if (b2_phase !== 3'd0) begin
            n_errors++;
            $display("FAIL place_other_slot: got %0d, want 0", b2_phase);
        end
        // Holding the key and then re-pressing it during the fuse must not re-latch.
        p1_tx = 4'd7; p1_ty = 4'd7;
        repeat (10) cyc();
        keycode = 8'h00;
        cyc();
        keycode = 8'h19;
        cyc();
        keycode = 8'h00;
        n_checks++;
        if ({b1_phase, b1_tx, b1_ty} !== {3'd1, 4'd3, 4'd5}) begin
            n_errors++;
            $display("FAIL place_rearm: got phase %0d pos (%0d,%0d), want phase 1 pos (3,5)",
                     b1_phase, b1_tx, b1_ty);
        end
    endtask

    // Continues from the bomb armed in test_placement (no ticks applied yet).
    task automatic test_phases();
        run_ticks(119);
        n_checks++;
        if (b1_phase !== 3'd1) begin
            n_errors++;
            $display("FAIL fuse_119: got %0d, want 1", b1_phase);
        end
        run_ticks(1);
        n_checks++;
        if (b1_phase !== 3'd2) begin
            n_errors++;
            $display("FAIL fuse_120: got %0d, want 2", b1_phase);
        end
        run_ticks(19);
        n_checks++;
        if (b1_phase !== 3'd2) begin
            n_errors++;
            $display("FAIL ex1_19: got %0d, want 2", b1_phase);
        end
        run_ticks(1);
        n_checks++;
        if (b1_phase !== 3'd3) begin
            n_errors++;
            $display("FAIL ex1_20: got %0d, want 3", b1_phase);
        end
        run_ticks(20);
        n_checks++;
        if (b1_phase !== 3'd4) begin
            n_errors++;
            $display("FAIL ex2_20: got %0d, want 4", b1_phase);
        end
        run_ticks(20);
        n_checks++;
        if (b1_phase !== 3'd0) begin
            n_errors++;
            $display("FAIL ex3_20: got %0d, want 0", b1_phase);
        end
        n_checks++;
        if ({p1die, p2die} !== 2'b00) begin
            n_errors++;
            $display("FAIL phases_no_death: got %b, want 00", {p1die, p2die});
        end
    endtask

    task automatic test_blast_radius();
        clear_state();
        p1_tx = 4'd3; p1_ty = 4'd5;
        p2_tx = 4'd5; p2_ty = 4'd5;
        keycode = 8'h19;
        cyc();
        keycode = 8'h00;
        p1_tx = 4'd4; p1_ty = 4'd6;
        run_ticks(120);
        repeat (3) cyc();
        n_checks++;
        if ({b1_phase, p1die, p2die} !== {3'd2, 2'b00}) begin
            n_errors++;
            $display("FAIL blast_ex1_r1: got phase %0d die %b, want phase 2 die 00",
                     b1_phase, {p1die, p2die});
        end
        run_ticks(20);
        n_checks++;
        if ({b1_phase, p2die} !== {3'd3, 1'b0}) begin
            n_errors++;
            $display("FAIL blast_ex2_entry: got phase %0d p2die %b, want phase 3 p2die 0",
                     b1_phase, p2die);
        end
        cyc();
        n_checks++;
        if (p2die !== 1'b1) begin
            n_errors++;
            $display("FAIL blast_ex2_r2: got p2die %b, want 1", p2die);
        end
        p2_tx = 4'd9; p2_ty = 4'd9;
        cyc();
        n_checks++;
        if (p2die !== 1'b1) begin
            n_errors++;
            $display("FAIL blast_sticky: got p2die %b, want 1", p2die);
        end
        run_ticks(20);
        run_ticks(19);
        n_checks++;
        if ({b1_phase, p1die} !== {3'd4, 1'b0}) begin
            n_errors++;
            $display("FAIL blast_diagonal: got phase %0d p1die %b, want phase 4 p1die 0",
                     b1_phase, p1die);
        end
        // Step into the blast on the very tick that ends EX3.
        p1_tx = 4'd3; p1_ty = 4'd4;
        run_ticks(1);
        n_checks++;
        if ({b1_phase, p1die} !== {3'd0, 1'b1}) begin
            n_errors++;
            $display("FAIL blast_last_tick: got phase %0d p1die %b, want phase 0 p1die 1",
                     b1_phase, p1die);
        end
        game_state = GS_OTHER;
        cyc();
        n_checks++;
        if ({p1die, p2die} !== 2'b00) begin
            n_errors++;
            $display("FAIL exit_clear: got %b, want 00", {p1die, p2die});
        end
        keycode = 8'h19;
        cyc();
        keycode = 8'h00;
        n_checks++;
        if (b1_phase !== 3'd0) begin
            n_errors++;
            $display("FAIL exit_no_place: got %0d, want 0", b1_phase);
        end
    endtask

    task automatic test_double_kill();
        clear_state();
        p1_tx = 4'd8; p1_ty = 4'd8;
        p2_tx = 4'd8; p2_ty = 4'd8;
        keycode = 8'h19;
        cyc();
        keycode = 8'h00;
        run_ticks(120);
        n_checks++;
        if ({b1_phase, p1die, p2die} !== {3'd2, 2'b00}) begin
            n_errors++;
            $display("FAIL double_entry: got phase %0d die %b, want phase 2 die 00",
                     b1_phase, {p1die, p2die});
        end
        cyc();
        n_checks++;
        if ({p1die, p2die} !== 2'b11) begin
            n_errors++;
            $display("FAIL double_kill: got %b, want 11", {p1die, p2die});
        end
        game_state = GS_PAUSE;
        repeat (5) cyc();
        n_checks++;
        if ({b1_phase, p1die, p2die} !== {3'd2, 2'b11}) begin
            n_errors++;
            $display("FAIL double_pause_hold: got phase %0d die %b, want phase 2 die 11",
                     b1_phase, {p1die, p2die});
        end
        game_state = GS_OTHER;
        cyc();
        n_checks++;
        if ({b1_phase, p1die, p2die} !== {3'd0, 2'b00}) begin
            n_errors++;
            $display("FAIL double_exit: got phase %0d die %b, want phase 0 die 00",
                     b1_phase, {p1die, p2die});
        end
    endtask

    task automatic test_pause();
        clear_state();
        p1_tx = 4'd0; p1_ty = 4'd14;
        p2_tx = 4'd1; p2_ty = 4'd1;
        keycode = 8'h13;
        cyc();
        keycode = 8'h00;
        n_checks++;
        if ({b2_phase, b2_tx, b2_ty} !== {3'd1, 4'd1, 4'd1}) begin
            n_errors++;
            $display("FAIL p2_place: got phase %0d pos (%0d,%0d), want phase 1 pos (1,1)",
                     b2_phase, b2_tx, b2_ty);
        end
        p2_tx = 4'd14; p2_ty = 4'd14;
        run_ticks(60);
        game_state = GS_PAUSE;
        run_ticks(50);
        n_checks++;
        if ({b2_phase, b2_tx, b2_ty} !== {3'd1, 4'd1, 4'd1}) begin
            n_errors++;
            $display("FAIL pause_freeze: got phase %0d pos (%0d,%0d), want phase 1 pos (1,1)",
                     b2_phase, b2_tx, b2_ty);
        end
        keycode = 8'h19;
        cyc();
        keycode = 8'h00;
        cyc();
        n_checks++;
        if (b1_phase !== 3'd0) begin
            n_errors++;
            $display("FAIL pause_no_place: got %0d, want 0", b1_phase);
        end
        game_state = GS_PLAY;
        run_ticks(59);
        n_checks++;
        if (b2_phase !== 3'd1) begin
            n_errors++;
            $display("FAIL resume_119: got %0d, want 1", b2_phase);
        end
        run_ticks(1);
        n_checks++;
        if (b2_phase !== 3'd2) begin
            n_errors++;
            $display("FAIL resume_120: got %0d, want 2", b2_phase);
        end
    endtask

    task automatic test_reset_mid();
        clear_state();
        p1_tx = 4'd3; p1_ty = 4'd5;
        p2_tx = 4'd3; p2_ty = 4'd6;
        keycode = 8'h19;
        cyc();
        keycode = 8'h00;
        p1_tx = 4'd10; p1_ty = 4'd10;
        run_ticks(140);
        cyc();
        n_checks++;
        if ({b1_phase, p2die} !== {3'd3, 1'b1}) begin
            n_errors++;
            $display("FAIL pre_reset: got phase %0d p2die %b, want phase 3 p2die 1",
                     b1_phase, p2die);
        end
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        n_checks++;
        if ({p1die, p2die, b1_tx, b1_ty, b2_tx, b2_ty, b1_phase, b2_phase} !== 24'd0) begin
            n_errors++;
            $display("FAIL reset_mid: got %h, want 0",
                     {p1die, p2die, b1_tx, b1_ty, b2_tx, b2_ty, b1_phase, b2_phase});
        end
    endtask

    initial begin
        test_reset();
        test_placement();
        test_phases();
        test_blast_radius();
        test_double_kill();
        test_pause();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
